// File: rtl/rrat_retire_pkg.sv
// Shared types and default sizing for the retirement RAT.
package rrat_retire_pkg;

    localparam int ARCH_REGS       = 32;
    localparam int PHYS_REGS       = 64;
    localparam int ARCH_WIDTH      = $clog2(ARCH_REGS);
    localparam int PHYS_WIDTH      = $clog2(PHYS_REGS);
    localparam int PROCESSOR_WIDTH = 2;
    localparam int RESTORE_LANES   = 8;

    typedef enum logic [0:0] {
        RRAT_IDLE = 1'b0,
        RRAT_COPY = 1'b1
    } rrat_state_t;

endpackage

// File: rtl/rrat_retire_restore_seq.sv
// Restore sequencer: walks the committed map one beat per cycle after a flush.
//
// state | meaning
// IDLE  | commits accepted; waiting for flush_req
// COPY  | one map beat on the outputs per cycle; commits stalled
module rrat_retire_restore_seq
    import rrat_retire_pkg::*;
#(
    parameter int NBEATS = 4,
    parameter int BEAT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_req,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              beat_valid,
    output logic              beat_done,
    output logic              ready
);

    localparam logic [0:0]        ST_IDLE   = 1'(RRAT_IDLE);
    localparam logic [0:0]        ST_COPY   = 1'(RRAT_COPY);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    logic [0:0]        state;
    logic [BEAT_W-1:0] beat_cnt;

    // State and beat counter; the counter only returns to zero on COPY->IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state    <= ST_COPY;
                        beat_cnt <= '0;
                    end
                end
                ST_COPY: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state    <= ST_IDLE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // All outputs decode straight from registers, so they are glitch-free beats.
    always_comb begin
        beat_idx   = beat_cnt;
        beat_valid = (state == ST_COPY);
        beat_done  = (state == ST_COPY) && (beat_cnt == LAST_BEAT);
        ready      = (state == ST_IDLE);
    end

endmodule

// File: rtl/rrat_retire.sv
// Retirement RAT: committed arch->phys map, in-order multi-lane commit with
// intra-group WAW resolution, displaced-preg return, and flush-time restore stream.
module rrat_retire #(
    parameter int COMMIT_W      = rrat_retire_pkg::PROCESSOR_WIDTH,
    parameter int ARCH_REGS     = rrat_retire_pkg::ARCH_REGS,
    parameter int PHYS_REGS     = rrat_retire_pkg::PHYS_REGS,
    parameter int RESTORE_LANES = rrat_retire_pkg::RESTORE_LANES,
    // derived widths, not meant to be overridden
    parameter int ARCH_W        = $clog2(ARCH_REGS),
    parameter int PHYS_W        = $clog2(PHYS_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COMMIT_W-1:0]                   commit_valid,
    input  logic [COMMIT_W-1:0][ARCH_W-1:0]       commit_arch,
    input  logic [COMMIT_W-1:0][PHYS_W-1:0]       commit_phys,
    output logic                                  commit_ready,
    output logic [COMMIT_W-1:0]                   free_valid,
    output logic [COMMIT_W-1:0][PHYS_W-1:0]       free_preg,
    input  logic                                  flush_req,
    output logic                                  restore_valid,
    output logic [ARCH_W-1:0]                     restore_base,
    output logic [RESTORE_LANES-1:0][PHYS_W-1:0]  restore_map,
    output logic                                  restore_done
);

    import rrat_retire_pkg::*;

    localparam int NBEATS = ARCH_REGS / RESTORE_LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [PHYS_W-1:0]                 map_q [ARCH_REGS];
    logic [PHYS_W-1:0]                 map_d [ARCH_REGS];
    logic [COMMIT_W-1:0]               lane_en;
    logic [COMMIT_W-1:0][PHYS_W-1:0]   displaced;
    logic [BEAT_W-1:0]                 beat_idx;
    logic                              beat_valid;
    logic                              beat_done;

    rrat_retire_restore_seq #(
        .NBEATS (NBEATS),
        .BEAT_W (BEAT_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .beat_idx   (beat_idx),
        .beat_valid (beat_valid),
        .beat_done  (beat_done),
        .ready      (commit_ready)
    );

    // A lane counts only when the block is accepting and it does not target x0.
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_en[i] = commit_ready && commit_valid[i] && (commit_arch[i] != '0);
        end
    end

    // Displaced preg: youngest older lane writing the same arch wins over the table.
    always_comb begin
        displaced = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            displaced[i] = map_q[commit_arch[i]];
            for (int k = 0; k < i; k++) begin
                if (lane_en[k] && (commit_arch[k] == commit_arch[i])) begin
                    displaced[i] = commit_phys[k];
                end
            end
        end
    end

    // Next map: lanes applied oldest first, so the youngest writer lands last.
    always_comb begin
        map_d = map_q;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (lane_en[i]) begin
                map_d[commit_arch[i]] = commit_phys[i];
            end
        end
    end

    // Map storage and registered free-list return.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
            free_valid <= '0;
            free_preg  <= '0;
        end else begin
            map_q      <= map_d;
            free_valid <= lane_en;
            for (int i = 0; i < COMMIT_W; i++) begin
                free_preg[i] <= lane_en[i] ? displaced[i] : '0;
            end
        end
    end

    // Restore beat mux; held at zero outside COPY so idle outputs stay quiet.
    always_comb begin
        restore_valid = beat_valid;
        restore_done  = beat_done;
        restore_base  = '0;
        restore_map   = '0;
        if (beat_valid) begin
            restore_base = ARCH_W'(int'(beat_idx) * RESTORE_LANES);
            for (int j = 0; j < RESTORE_LANES; j++) begin
                restore_map[j] = map_q[ARCH_W'(int'(beat_idx) * RESTORE_LANES + j)];
            end
        end
    end

endmodule
